// File: rtl/i2c_cmd_fifo.sv
// Command FIFO between the AXI slave and the I2C master.
// First-word fall-through: the head word is visible on M_DATA whenever M_VALID is high.
// Each word holds a 7-bit target address, a R/W bit and a data byte.
module i2c_cmd_fifo #(
   parameter int unsigned ENTRY_WIDTH = 16,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AF_LEVEL    = DEPTH - 2
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   input  logic                     S_VALID,
   input  logic [ENTRY_WIDTH-1:0]   S_DATA,
   output logic                     S_READY,
   output logic                     M_VALID,
   output logic [ENTRY_WIDTH-1:0]   M_DATA,
   input  logic                     M_READY,
   input  logic                     FLUSH,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     ALMOST_FULL,
   output logic                     OVERFLOW,
   input  logic                     OVF_CLR,
   output logic                     PENDING
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
   localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);

   logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovf_q, ovf_d;
   // Low through reset, set on the first edge after release; holds S_READY low until then.
   logic                   init_q;
   logic                   full, empty, wr_en, rd_en;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);

   assign S_READY     = init_q & ~full;
   assign M_VALID     = ~empty;
   assign PENDING     = ~empty;
   assign COUNT       = count_q;
   assign ALMOST_FULL = init_q & (count_q >= AfCnt);
   assign OVERFLOW    = ovf_q;
   assign M_DATA      = mem_q[rd_ptr_q];

   // Flush overrides both handshakes for the cycle.
   assign wr_en = S_VALID & S_READY & ~FLUSH;
   assign rd_en = M_VALID & M_READY & ~FLUSH;

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
         end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
         end
      end

      // Set beats clear when both happen together.
      if (S_VALID && full && !FLUSH) begin
         ovf_d = 1'b1;
      end else if (OVF_CLR) begin
         ovf_d = 1'b0;
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         init_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         init_q   <= 1'b1;
      end
   end

   // Storage array; deliberately not reset or flushed, only pointers are.
   always_ff @(posedge ACLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= S_DATA;
      end
   end

endmodule

// File: tb/tb_i2c_cmd_fifo.sv
// Scoreboard bench for i2c_cmd_fifo: a queue-based reference model tracks contents,
// a negedge monitor compares status and pops on each read handshake.
module tb_i2c_cmd_fifo;

   localparam int unsigned EW  = 16;
   localparam int unsigned DEP = 8;
   localparam int unsigned AF  = DEP - 2;

   logic          ACLK;
   logic          ARESETn;
   logic          S_VALID;
   logic [EW-1:0] S_DATA;
   logic          S_READY;
   logic          M_VALID;
   logic [EW-1:0] M_DATA;
   logic          M_READY;
   logic          FLUSH;
   logic [3:0]    COUNT;
   logic          ALMOST_FULL;
   logic          OVERFLOW;
   logic          OVF_CLR;
   logic          PENDING;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [EW-1:0] exp_q[$];
   bit            ovf_model = 1'b0;
   bit            rdy_model = 1'b0;
   int            pre_size  = 0;

   i2c_cmd_fifo #(
      .ENTRY_WIDTH (EW),
      .DEPTH       (DEP),
      .AF_LEVEL    (AF)
   ) dut (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .S_VALID     (S_VALID),
      .S_DATA      (S_DATA),
      .S_READY     (S_READY),
      .M_VALID     (M_VALID),
      .M_DATA      (M_DATA),
      .M_READY     (M_READY),
      .FLUSH       (FLUSH),
      .COUNT       (COUNT),
      .ALMOST_FULL (ALMOST_FULL),
      .OVERFLOW    (OVERFLOW),
      .OVF_CLR     (OVF_CLR),
      .PENDING     (PENDING)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at the active edge, from the inputs the DUT sees at that edge.
   always @(posedge ACLK) begin
      if (!ARESETn) begin
         exp_q.delete();
         ovf_model = 1'b0;
         rdy_model = 1'b0;
      end else begin
         if (FLUSH) begin
            exp_q.delete();
         end else if (S_VALID && rdy_model && pre_size < int'(DEP)) begin
            exp_q.push_back(S_DATA);
         end
         if (S_VALID && !FLUSH && pre_size == int'(DEP)) begin
            ovf_model = 1'b1;
         end else if (OVF_CLR) begin
            ovf_model = 1'b0;
         end
         rdy_model = 1'b1;
      end
   end

   // Monitor: compare DUT against model mid-cycle, pop on a read handshake.
   always @(negedge ACLK) begin
      int sz;
      if (!ARESETn) begin
         chk("rst_count", 32'(COUNT), 0);
         chk("rst_m_valid", 32'(M_VALID), 0);
         chk("rst_s_ready", 32'(S_READY), 0);
         chk("rst_pending", 32'(PENDING), 0);
         chk("rst_almost_full", 32'(ALMOST_FULL), 0);
         chk("rst_overflow", 32'(OVERFLOW), 0);
         pre_size = 0;
      end else begin
         sz = exp_q.size();
         chk("count", 32'(COUNT), 32'(sz));
         chk("m_valid", 32'(M_VALID), 32'(sz != 0));
         chk("s_ready", 32'(S_READY), 32'(rdy_model && sz < int'(DEP)));
         chk("almost_full", 32'(ALMOST_FULL), 32'(sz >= int'(AF)));
         chk("pending", 32'(PENDING), 32'(sz != 0));
         chk("overflow", 32'(OVERFLOW), 32'(ovf_model));
         if (sz != 0) chk("m_data", 32'(M_DATA), 32'(exp_q[0]));
         pre_size = sz;
         if (sz != 0 && M_READY && !FLUSH) void'(exp_q.pop_front());
      end
   end

   // Drive one cycle's inputs (called just after an active edge), then advance one cycle.
   task automatic step(input logic sv, input logic [EW-1:0] sd, input logic mr,
                       input logic fl, input logic oc);
      S_VALID = sv;
      S_DATA  = sd;
      M_READY = mr;
      FLUSH   = fl;
      OVF_CLR = oc;
      @(posedge ACLK);
      #1;
   endtask

   task automatic drain(input int cycles);
      for (int k = 0; k < cycles; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      int i;
      int guard;
      ARESETn = 1'b0;
      S_VALID = 1'b0;
      S_DATA  = '0;
      M_READY = 1'b0;
      FLUSH   = 1'b0;
      OVF_CLR = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Single write into empty FIFO.
      step(1'b1, 16'hA055, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Fill to 8, then a 9th attempt sets overflow.
      for (int k = 1; k < 8; k++) step(1'b1, 16'(16'h1100 + k), 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Full with both handshakes: read only; then both at 7 hold the count.
      step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0);

      // Down to 5, then flush with a concurrent write; overflow must survive.
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Stream 0..19 with random stalls, crossing the pointer wrap.
      i = 0;
      guard = 0;
      while (i < 20 && guard < 400) begin
         S_VALID = 1'b1;
         S_DATA  = 16'(i);
         M_READY = 1'($urandom_range(0, 1));
         FLUSH   = 1'b0;
         OVF_CLR = 1'b0;
         if (S_READY) i++;
         @(posedge ACLK);
         #1;
         guard++;
      end
      chk("stream_done", 32'(i), 20);
      drain(DEP + 2);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0));
      end
      drain(DEP + 2);

      // Asynchronous reset mid-cycle with three entries held.
      for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h4400 + k), 1'b0, 1'b0, 1'b0);
      S_VALID = 1'b0;
      #1;
      ARESETn = 1'b0;
      #1;
      chk("async_count", 32'(COUNT), 0);
      chk("async_m_valid", 32'(M_VALID), 0);
      chk("async_s_ready", 32'(S_READY), 0);
      chk("async_pending", 32'(PENDING), 0);
      chk("async_almost_full", 32'(ALMOST_FULL), 0);
      chk("async_overflow", 32'(OVERFLOW), 0);
      @(posedge ACLK);
      #1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      ARESETn = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h6B6B, 1'b1, 1'b0, 1'b0);
      drain(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
